teste2_can_decoder: RTL and testbench

TESTE2_CAN_DECODER -- requirements
Module: teste2_can_decoder

---
 rtl/teste2_can_decoder_pkg.sv | 29 ++
 rtl/teste2_can_decoder_if.sv | 29 ++
 rtl/teste2_can_decoder.sv | 134 +++++++++++++
 tb/tb_teste2_can_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/teste2_can_decoder_pkg.sv
// Shared constants, state encoding and result record for the CAN header decoder.
package teste2_can_pkg;

  localparam int ID_A_W  = 11;
  localparam int ID_B_W  = 18;
  localparam int DLC_W   = 4;
  localparam int EOF_LEN = 7;
  localparam int CNT_W   = 5;

  typedef enum logic [3:0] {
    IDLE, ID_A, BIT12, IDE, ID_B, RTR_E, R1, R0, DLC, WAIT_EOF
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ID_A_W-1:0] id_a;
    logic [ID_B_W-1:0] id_b;
    logic              srr_rtr;
    logic              ide;
    logic              rtr;
    logic [DLC_W-1:0]  dlc;
  } frame_t;

  // Counter value seen on the last bit of a field that is w bits long.
  function automatic logic [CNT_W-1:0] last_idx(input int w);
    return CNT_W'(w - 1);
  endfunction

endpackage

// File: rtl/teste2_can_decoder_if.sv
// Serial CAN bit input and decoded header results, grouped as one bundle.
interface teste2_can_decoder_if;
  import teste2_can_pkg::*;

  logic              can_data;
  logic              getframe;
  logic [ID_A_W-1:0] bit_id_11;
  logic [28:0]       bit_id_29;
  logic [1:0]        srr_rtr_ide;
  logic              std_frame;
  logic              ext_frame;
  logic              rtr_ext;
  logic              remote_frame;
  logic              data_frame;
  logic [DLC_W-1:0]  data_size;

  modport master (
    output can_data,
    input  getframe, bit_id_11, bit_id_29, srr_rtr_ide, std_frame, ext_frame,
           rtr_ext, remote_frame, data_frame, data_size
  );

  modport slave (
    input  can_data,
    output getframe, bit_id_11, bit_id_29, srr_rtr_ide, std_frame, ext_frame,
           rtr_ext, remote_frame, data_frame, data_size
  );

endinterface

// File: rtl/teste2_can_decoder.sv
// CAN arbitration/control header decoder: one FSM, one shared bit counter,
// results published together with a single-cycle getframe strobe.
module teste2_can_decoder
  import teste2_can_pkg::*;
(
  input  logic               sample,
  input  logic               reset,
  teste2_can_decoder_if.slave bus
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ID_A_W-1:0]  id_a_sr;
  logic [ID_B_W-1:0]  id_b_sr;
  logic [DLC_W-2:0]   dlc_sr;
  logic               bit12_q, ide_q, rtr_e_q;
  logic               done, ide_now, rtr_now;
  logic               getframe_q;
  frame_t             res, res_n;

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge sample) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    case (state)
      IDLE:  if (!bus.can_data) begin state_n = ID_A; cnt_n = '0; end
      ID_A:  if (cnt == last_idx(ID_A_W)) begin state_n = BIT12; cnt_n = '0; end
             else cnt_n = cnt + CNT_W'(1);
      BIT12: state_n = IDE;
      IDE: begin
        if (bus.can_data) begin
          state_n = ID_B;
          cnt_n   = '0;
        end else if (bit12_q) begin
          done    = 1'b1;
          state_n = WAIT_EOF;
          cnt_n   = '0;
        end else begin
          state_n = R0;
        end
      end
      ID_B:  if (cnt == last_idx(ID_B_W)) begin state_n = RTR_E; cnt_n = '0; end
             else cnt_n = cnt + CNT_W'(1);
      RTR_E: state_n = R1;
      R1: begin
        if (rtr_e_q) begin
          done    = 1'b1;
          state_n = WAIT_EOF;
          cnt_n   = '0;
        end else begin
          state_n = R0;
        end
      end
      R0:    begin state_n = DLC; cnt_n = '0; end
      DLC: begin
        if (cnt == last_idx(DLC_W)) begin
          done    = 1'b1;
          state_n = WAIT_EOF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_EOF: begin
        if (!bus.can_data)                 cnt_n = '0;
        else if (cnt == last_idx(EOF_LEN)) begin state_n = IDLE; cnt_n = '0; end
        else                               cnt_n = cnt + CNT_W'(1);
      end
      default: begin state_n = IDLE; cnt_n = '0; end
    endcase
  end

  // Completing bit may itself be the IDE bit or the last DLC bit, so merge it in here.
  always_comb begin
    ide_now       = (state == IDE) ? bus.can_data : ide_q;
    rtr_now       = ide_now ? rtr_e_q : bit12_q;
    res_n.valid   = 1'b1;
    res_n.id_a    = id_a_sr;
    res_n.id_b    = id_b_sr;
    res_n.srr_rtr = bit12_q;
    res_n.ide     = ide_now;
    res_n.rtr     = rtr_now;
    res_n.dlc     = rtr_now ? '0 : {dlc_sr, bus.can_data};
  end

  always_ff @(posedge sample) begin
    if (reset) begin
      id_a_sr    <= '0;
      id_b_sr    <= '0;
      dlc_sr     <= '0;
      bit12_q    <= 1'b0;
      ide_q      <= 1'b0;
      rtr_e_q    <= 1'b0;
      getframe_q <= 1'b0;
      res        <= '0;
    end else begin
      getframe_q <= done;
      if (done) res <= res_n;
      case (state)
        ID_A:    id_a_sr <= {id_a_sr[ID_A_W-2:0], bus.can_data};
        BIT12:   bit12_q <= bus.can_data;
        IDE:     ide_q   <= bus.can_data;
        ID_B:    id_b_sr <= {id_b_sr[ID_B_W-2:0], bus.can_data};
        RTR_E:   rtr_e_q <= bus.can_data;
        DLC:     dlc_sr  <= {dlc_sr[DLC_W-3:0], bus.can_data};
        default: ;
      endcase
    end
  end

  assign bus.getframe     = getframe_q;
  assign bus.bit_id_11    = res.id_a;
  assign bus.bit_id_29    = res.ide ? {res.id_a, res.id_b} : '0;
  assign bus.srr_rtr_ide  = {res.srr_rtr, res.ide};
  assign bus.std_frame    = res.valid & ~res.ide;
  assign bus.ext_frame    = res.ide;
  assign bus.rtr_ext      = res.ide & res.rtr;
  assign bus.remote_frame = res.rtr;
  assign bus.data_frame   = res.valid & ~res.rtr;
  assign bus.data_size    = res.dlc;

endmodule

// File: tb/tb_teste2_can_decoder.sv
// Bench for teste2_can_decoder: fixed frame vectors, corner sequences and random
// bit streams compared every cycle against a header-position reference model.
module tb_teste2_can_decoder;
  import teste2_can_pkg::*;

  logic sample = 1'b0;
  logic reset  = 1'b1;

  teste2_can_decoder_if bus();
  teste2_can_decoder dut (.sample(sample), .reset(reset), .bus(bus));

  always #5 sample = ~sample;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic [63:0]   bits;
    int            len;
    int            pulse_at;
    logic [50:0]   exp;
  } vec_t;

  vec_t vecs[4];

  // Reference model: collects header bits by position from SOF.
  int          m_mode;
  int          m_hlen;
  int          m_ones;
  logic        m_hdr [0:38];
  logic        m_get;
  logic [50:0] m_out;

  int   nbits, pulses, pulse_pos;
  logic q[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [50:0] pack_out(logic [10:0] id11, logic [28:0] id29,
      logic [1:0] sri, logic s, logic e, logic re, logic rm, logic d, logic [3:0] sz);
    return {id11, id29, sri, s, e, re, rm, d, sz};
  endfunction

  function automatic logic [50:0] dut_out();
    return {bus.bit_id_11, bus.bit_id_29, bus.srr_rtr_ide, bus.std_frame, bus.ext_frame,
            bus.rtr_ext, bus.remote_frame, bus.data_frame, bus.data_size};
  endfunction

  function automatic vec_t make_vec(string n, logic [63:0] b, int l, int p, logic [50:0] e);
    vec_t v;
    v.name = n; v.bits = b; v.len = l; v.pulse_at = p; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (bit %0d)", name, act, exp, nbits);
    end
  endtask

  task model_step(input logic b, input logic r);
    logic [10:0] ida;
    logic [17:0] idb;
    logic [3:0]  dlc;
    logic        ide, rtr;
    int          base;
    m_get = 1'b0;
    if (r) begin
      m_mode = 0; m_hlen = 0; m_ones = 0; m_out = '0;
      return;
    end
    case (m_mode)
      0: if (!b) begin m_mode = 1; m_hdr[0] = 1'b0; m_hlen = 1; end
      1: begin
        m_hdr[m_hlen] = b;
        m_hlen++;
        if ((m_hlen == 14 && !m_hdr[13] && m_hdr[12]) || (m_hlen == 19 && !m_hdr[13]) ||
            (m_hlen == 34 && m_hdr[13] && m_hdr[32]) || m_hlen == 39) begin
          for (int k = 0; k < 11; k++) ida[10-k] = m_hdr[1+k];
          for (int k = 0; k < 18; k++) idb[17-k] = m_hdr[14+k];
          ide  = m_hdr[13];
          rtr  = ide ? m_hdr[32] : m_hdr[12];
          base = ide ? 35 : 15;
          dlc  = '0;
          if (!rtr) for (int k = 0; k < 4; k++) dlc[3-k] = m_hdr[base+k];
          m_out = pack_out(ida, ide ? {ida, idb} : 29'h0, {m_hdr[12], ide},
                           !ide, ide, ide & rtr, rtr, !rtr, dlc);
          m_get  = 1'b1;
          m_mode = 2;
          m_ones = 0;
        end
      end
      default: begin
        if (b) begin
          m_ones++;
          if (m_ones == EOF_LEN) m_mode = 0;
        end else begin
          m_ones = 0;
        end
      end
    endcase
  endtask

  task automatic step(input logic b, input logic r);
    bus.can_data = b;
    reset        = r;
    @(posedge sample);
    model_step(b, r);
    #1;
    nbits++;
    check("step", 64'({bus.getframe, dut_out()}), 64'({m_get, m_out}));
    if (bus.getframe) begin
      pulses++;
      pulse_pos = nbits;
    end
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v);
    nbits = 0; pulses = 0; pulse_pos = -1;
    for (int i = 1; i <= v.len; i++) step(v.bits[v.len-i], 1'b0);
    check({v.name, "_pulses"}, 64'(pulses), 64'd1);
    check({v.name, "_pulse_bit"}, 64'(pulse_pos), 64'(v.pulse_at));
    check({v.name, "_fields"}, 64'(dut_out()), 64'(v.exp));
  endtask

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) q.push_back(v[k]);
  endtask

  initial begin
    vecs[0] = make_vec("std_data",
      64'({5'b11111, 1'b0, 11'h551, 1'b0, 1'b0, 1'b0, 4'b0100}), 24, 24,
      pack_out(11'h551, 29'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4));
    vecs[1] = make_vec("std_remote",
      64'({5'b11111, 1'b0, 11'h551, 1'b1, 1'b0}), 19, 19,
      pack_out(11'h551, 29'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    vecs[2] = make_vec("ext_data",
      64'({2'b11, 1'b0, 11'h552, 1'b1, 1'b1, 18'h08320, 1'b0, 1'b0, 1'b0, 4'b1000}), 41, 41,
      pack_out(11'h552, 29'h15488320, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8));
    vecs[3] = make_vec("ext_remote",
      64'({2'b11, 1'b0, 11'h552, 1'b1, 1'b1, 18'h08320, 1'b1, 1'b0}), 36, 36,
      pack_out(11'h552, 29'h15488320, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));

    nbits = 0; pulses = 0; pulse_pos = -1;
    bus.can_data = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_state", 64'({bus.getframe, dut_out()}), 64'd0);

    for (int v = 0; v < 4; v++) begin
      apply_vec(vecs[v]);
      ones(8);
      check({vecs[v].name, "_hold"}, 64'(dut_out()), 64'(vecs[v].exp));
    end

    // Reset inside ID_A aborts the frame, clears results; next frame decodes.
    pulses = 0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'(i[0]), 1'b0);
    step(1'b1, 1'b1);
    check("abort_no_pulse", 64'(pulses), 64'd0);
    check("abort_cleared", 64'(dut_out()), 64'd0);
    apply_vec(vecs[0]);

    // A 0 after only 6 EOF ones is not SOF; a 0 after 7 ones is.
    ones(6);
    pulses = 0;
    step(1'b0, 1'b0);
    push_bits(64'({11'h551, 1'b1, 1'b0}), 13);
    while (q.size() > 0) step(q.pop_front(), 1'b0);
    check("eof_short_no_frame", 64'(pulses), 64'd0);
    ones(7);
    apply_vec(vecs[1]);
    ones(8);

    // Reset on the completing edge wins over the completion.
    pulses = 0;
    for (int i = 1; i < 19; i++) step(vecs[1].bits[19-i], 1'b0);
    step(vecs[1].bits[0], 1'b1);
    check("reset_priority_pulse", 64'(pulses), 64'd0);
    check("reset_priority_fields", 64'(dut_out()), 64'd0);
    ones(8);

    // Randomized frames with random payload/trailer and occasional resets.
    for (int f = 0; f < 40; f++) begin
      logic       ext, rtr;
      logic [3:0] dlc;
      int         rst_at;
      ext = 1'($urandom_range(0, 1));
      rtr = 1'($urandom_range(0, 1));
      dlc = 4'($urandom_range(0, 15));
      push_bits(64'h0, 0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) q.push_back(1'b1);
      q.push_back(1'b0);
      push_bits(64'($urandom), 11);
      if (ext) begin
        q.push_back(1'($urandom_range(0, 1)));
        q.push_back(1'b1);
        push_bits(64'($urandom), 18);
        q.push_back(rtr);
        q.push_back(1'($urandom_range(0, 1)));
      end else begin
        q.push_back(rtr);
        q.push_back(1'b0);
      end
      if (!rtr) begin
        q.push_back(1'($urandom_range(0, 1)));
        push_bits(64'(dlc), 4);
        push_bits(64'($urandom), int'($urandom_range(0, 16)));
      end
      push_bits(64'($urandom), 15);
      for (int i = 0; i < int'($urandom_range(7, 9)); i++) q.push_back(1'b1);
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      for (int i = 0; q.size() > 0; i++) step(q.pop_front(), i == rst_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
